// File: rtl/tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator: channel state
// encoding and the elaboration-time divisor width check.
package tick_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  // True when div is representable in an unsigned field of the given width.
  function automatic bit div_fits(input longint unsigned div, input int unsigned width);
    if (width >= 64) return 1'b1;
    return (div >> width) == 64'd0;
  endfunction

endpackage

// File: rtl/tick_gen_multi_channel.sv
// One tick channel: shadow/active divisor pair, period counter and the
// IDLE/RUN sequencer producing a registered one-cycle tick.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned          CNT_W   = 27,
  parameter logic [CNT_W-1:0]     DEF_DIV = '0
) (
  input  logic             clk100Mhz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             div_we,
  input  logic [CNT_W-1:0] div_in,
  output logic             tick,
  output logic             active
);

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_shd;
  logic [CNT_W-1:0] div_act, div_act_nxt;
  logic             mode_l, mode_nxt;
  logic             tick_nxt;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    div_act_nxt = div_act;
    mode_nxt    = mode_l;
    tick_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en && (!mode || start)) begin
          state_nxt   = ST_RUN;
          cnt_nxt     = '0;
          div_act_nxt = div_shd;
          mode_nxt    = mode;
        end
      end
      ST_RUN: begin
        // Priority: disable, then retrigger, then terminal count.
        if (!en) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (start) begin
          cnt_nxt     = '0;
          div_act_nxt = div_shd;
        end else if (cnt == div_act - CNT_W'(1)) begin
          cnt_nxt     = '0;
          tick_nxt    = 1'b1;
          div_act_nxt = div_shd;
          if (mode_l) state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      div_shd <= DEF_DIV;
      div_act <= DEF_DIV;
      mode_l  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div_act <= div_act_nxt;
      mode_l  <= mode_nxt;
      tick    <= tick_nxt;
      if (div_we) div_shd <= div_in;
    end
  end

  assign active = (state == ST_RUN);

endmodule

// File: rtl/tick_gen_multi.sv
// NUM_CH-channel programmable tick generator: divisor write decode and
// validation, error pulse, and one tick_channel per channel.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter  int unsigned CLK_FREQ      = 100_000_000,
  parameter  int unsigned DEF_TICK_FREQ = 1000,
  parameter  int unsigned NUM_CH        = 4,
  parameter  int unsigned CNT_W         = 27,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk100Mhz,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0] start,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active,
  output logic              cfg_err
);

  localparam longint unsigned  DEF_DIV_L = 64'(CLK_FREQ) / 64'(DEF_TICK_FREQ);
  localparam logic [CNT_W-1:0] DEF_DIV   = CNT_W'(DEF_DIV_L);

  if (!div_fits(DEF_DIV_L, CNT_W)) begin : g_bad_cnt_w
    $error("tick_gen_multi: CNT_W too narrow to hold CLK_FREQ/DEF_TICK_FREQ");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("tick_gen_multi: NUM_CH must be in 1..16");
  end

  logic ch_ok, div_ok, cfg_ok;

  // Channel index can exceed NUM_CH only when NUM_CH is not a power of two.
  assign ch_ok  = {1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH);
  assign div_ok = cfg_div >= CNT_W'(2);
  assign cfg_ok = ch_ok && div_ok;

  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_we && !cfg_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we;
    assign we = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));

    tick_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk100Mhz (clk100Mhz),
      .rst_n     (rst_n),
      .en        (en[i]),
      .mode      (mode[i]),
      .start     (start[i]),
      .div_we    (we),
      .div_in    (cfg_div),
      .tick      (tick[i]),
      .active    (active[i])
    );
  end

endmodule
